// File: rtl/mem_fill_master.sv
// Avalon-MM fill master: writes a constant or incrementing word pattern over a
// programmed word range, configured through a four-register Avalon-MM slave.
module mem_fill_master #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic [31:0] m_writedata,
  output logic        m_write,
  input  logic        m_waitrequest,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;

  logic [31:0]        base_r;
  logic [LEN_W-1:0]   length_r;
  logic [31:0]        pattern_r;
  logic               inc_r;
  logic               irq_en_r;
  logic               done_r;
  logic               abort_pend_r;
  logic [LEN_W-1:0]   cnt_r;

  logic               ctrl_wr_s;
  logic               go_s;
  logic               clr_s;
  logic               abort_s;
  logic               busy_s;
  logic               accept_s;
  logic               last_s;
  logic               len_zero_s;
  logic               start_s;
  logic               zero_go_s;

  assign ctrl_wr_s  = s_write && (s_address == 2'd0);
  assign go_s       = ctrl_wr_s && s_writedata[0];
  assign clr_s      = ctrl_wr_s && s_writedata[3];
  assign abort_s    = ctrl_wr_s && s_writedata[4];
  assign busy_s     = (state_r == ST_RUN);
  assign accept_s   = m_write && !m_waitrequest;
  // The final word, or the first word accepted once an abort is pending, ends the run.
  assign last_s     = busy_s && accept_s &&
                      ((cnt_r == LEN_W'(1'b1)) || abort_pend_r);
  assign len_zero_s = (length_r == {LEN_W{1'b0}});
  assign start_s    = !busy_s && go_s && !len_zero_s;
  assign zero_go_s  = !busy_s && go_s && len_zero_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; FINISH lasts one cycle but can already accept a new GO
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_FINISH: begin
        if (go_s) begin
          state_s = len_zero_s ? ST_FINISH : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Configuration registers; mode bits update any time, range/pattern only when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r    <= 32'd0;
      length_r  <= {LEN_W{1'b0}};
      pattern_r <= 32'd0;
      inc_r     <= 1'b0;
      irq_en_r  <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        inc_r    <= s_writedata[1];
        irq_en_r <= s_writedata[2];
      end
      if (s_write && !busy_s) begin
        case (s_address)
          2'd1:    base_r    <= {s_writedata[31:2], 2'b00};
          2'd2:    length_r  <= s_writedata[LEN_W-1:0];
          2'd3:    pattern_r <= s_writedata;
          default: ;
        endcase
      end
    end
  end

  // Master write datapath: only advances on an accepted beat, so a stalled beat stays put
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_address    <= 32'd0;
      m_writedata  <= 32'd0;
      m_write      <= 1'b0;
      cnt_r        <= {LEN_W{1'b0}};
      abort_pend_r <= 1'b0;
    end else begin
      if (start_s) begin
        m_address   <= base_r;
        m_writedata <= pattern_r;
        m_write     <= 1'b1;
        cnt_r       <= length_r;
      end else if (busy_s && accept_s) begin
        m_address <= m_address + 32'd4;
        if (inc_r) begin
          m_writedata <= m_writedata + 32'd1;
        end
        cnt_r <= cnt_r - LEN_W'(1'b1);
        if (last_s) begin
          m_write <= 1'b0;
        end
      end
      if (busy_s && !last_s && abort_s) begin
        abort_pend_r <= 1'b1;
      end else if (!busy_s || last_s) begin
        abort_pend_r <= 1'b0;
      end
    end
  end

  // Completion flag and level interrupt; a GO that starts a run clears DONE even with CLR_DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_r <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (start_s) begin
        done_r <= 1'b0;
      end else if (zero_go_s || last_s) begin
        done_r <= 1'b1;
      end else if (clr_s) begin
        done_r <= 1'b0;
      end
      irq <= done_r && irq_en_r;
    end
  end

  // Registered slave read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= 32'd0;
    end else if (s_read) begin
      case (s_address)
        2'd0:    s_readdata <= {28'd0, done_r, irq_en_r, inc_r, busy_s};
        2'd1:    s_readdata <= base_r;
        2'd2:    s_readdata <= 32'(length_r);
        2'd3:    s_readdata <= pattern_r;
        default: s_readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_master.sv
// Directed self-checking bench for mem_fill_master.
module tb_mem_fill_master;

  logic        clk;
  logic        reset_n;
  logic [1:0]  s_address;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_read;
  logic [31:0] s_readdata;
  logic [31:0] m_address;
  logic [31:0] m_writedata;
  logic        m_write;
  logic        m_waitrequest;
  logic        irq;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int acc_cnt  = 0;
  int wr_cnt   = 0;

  mem_fill_master #(.LEN_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_address     (s_address),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_read        (s_read),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_write       (m_write),
    .m_waitrequest (m_waitrequest),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: accepted beats and cycles with m_write asserted
  always @(posedge clk) begin
    if (m_write && !m_waitrequest) acc_cnt <= acc_cnt + 1;
    if (m_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_write = 1'b1; s_address = a; s_writedata = d;
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    s_read = 1'b1; s_address = a;
    @(posedge clk); #1;
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!m_write) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0; s_address = 2'd0; s_write = 1'b0; s_writedata = 32'd0;
    s_read = 1'b0; m_waitrequest = 1'b0;
    #23;
    chk_cnt++;
    if ({m_write, irq, m_address, m_writedata, s_readdata} !== 98'd0)
      $display("FAIL reset_outputs: got wr=%b irq=%b addr=%h data=%h rd=%h, want all 0",
               m_write, irq, m_address, m_writedata, s_readdata);
    else pass_cnt++;
    reset_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reg_read(r[1:0], rd);
      chk_cnt++;
      if (rd !== 32'd0) $display("FAIL reset_reg%0d: got %h want 00000000", r, rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_const_fill();
    logic [31:0] rd;
    int a0;
    reg_write(2'd1, 32'h0000_0100);
    reg_write(2'd2, 32'd4);
    reg_write(2'd3, 32'hA5A5_A5A5);
    a0 = acc_cnt;
    reg_write(2'd0, 32'h0000_0001);
    s_address = 2'd0; s_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (m_write !== 1'b1 || m_address !== 32'h100 + 32'(4 * i) || m_writedata !== 32'hA5A5_A5A5)
        $display("FAIL const_word%0d: got wr=%b addr=%h data=%h want 1 %h a5a5a5a5",
                 i, m_write, m_address, m_writedata, 32'h100 + 32'(4 * i));
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++;
        if (s_readdata !== 32'h1) $display("FAIL const_busy%0d: got %h want 00000001", i, s_readdata);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    s_read = 1'b0;
    chk_cnt++;
    if (m_write !== 1'b0 || acc_cnt - a0 !== 4)
      $display("FAIL const_end: got wr=%b accepts=%0d want 0 4", m_write, acc_cnt - a0);
    else pass_cnt++;
    reg_read(2'd0, rd);
    chk_cnt++;
    if (rd !== 32'h8) $display("FAIL const_status: got %h want 00000008", rd);
    else pass_cnt++;
  endtask

  task automatic test_inc_wrap();
    logic [31:0] rd;
    logic [31:0] ea [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] ed [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    reg_write(2'd1, 32'hFFFF_FFFB);
    reg_read(2'd1, rd);
    chk_cnt++;
    if (rd !== 32'hFFFF_FFF8) $display("FAIL base_align: got %h want fffffff8", rd);
    else pass_cnt++;
    reg_write(2'd2, 32'd3);
    reg_write(2'd3, 32'hFFFF_FFFE);
    reg_write(2'd0, 32'h0000_0003);
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (m_write !== 1'b1 || m_address !== ea[i] || m_writedata !== ed[i])
        $display("FAIL wrap_word%0d: got wr=%b addr=%h data=%h want 1 %h %h",
                 i, m_write, m_address, m_writedata, ea[i], ed[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (m_write !== 1'b0) $display("FAIL wrap_end: got wr=%b want 0", m_write);
    else pass_cnt++;
  endtask

  task automatic test_waitrequest();
    int a0;
    reg_write(2'd1, 32'h0000_0200);
    reg_write(2'd2, 32'd3);
    reg_write(2'd3, 32'h0000_0010);
    a0 = acc_cnt;
    reg_write(2'd0, 32'h0000_0003);
    @(posedge clk); #1;
    m_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (m_write !== 1'b1 || m_address !== 32'h204 || m_writedata !== 32'h11)
        $display("FAIL stall_hold%0d: got wr=%b addr=%h data=%h want 1 00000204 00000011",
                 k, m_write, m_address, m_writedata);
      else pass_cnt++;
    end
    m_waitrequest = 1'b0;
    wait_idle();
    chk_cnt++;
    if (m_write !== 1'b0 || acc_cnt - a0 !== 3)
      $display("FAIL stall_accepts: got wr=%b accepts=%0d want 0 3", m_write, acc_cnt - a0);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int a0;
    reg_write(2'd1, 32'h0000_0300);
    reg_write(2'd2, 32'd8);
    reg_write(2'd3, 32'h0000_0077);
    m_waitrequest = 1'b1;
    a0 = acc_cnt;
    reg_write(2'd0, 32'h0000_0001);
    reg_write(2'd0, 32'h0000_0010);
    chk_cnt++;
    if (m_write !== 1'b1 || m_address !== 32'h300)
      $display("FAIL abort_hold: got wr=%b addr=%h want 1 00000300", m_write, m_address);
    else pass_cnt++;
    m_waitrequest = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (m_write !== 1'b0 || acc_cnt - a0 !== 1)
      $display("FAIL abort_stop: got wr=%b accepts=%0d want 0 1", m_write, acc_cnt - a0);
    else pass_cnt++;
    reg_read(2'd0, rd);
    chk_cnt++;
    if (rd !== 32'h8) $display("FAIL abort_status: got %h want 00000008", rd);
    else pass_cnt++;
  endtask

  task automatic test_zero_len_irq();
    logic [31:0] rd;
    int w0;
    reg_write(2'd2, 32'd0);
    w0 = wr_cnt;
    reg_write(2'd0, 32'h0000_0005);
    @(posedge clk); #1;
    chk_cnt++;
    if (irq !== 1'b1 || m_write !== 1'b0)
      $display("FAIL zero_irq: got irq=%b wr=%b want 1 0", irq, m_write);
    else pass_cnt++;
    reg_read(2'd0, rd);
    chk_cnt++;
    if (rd !== 32'hC || wr_cnt !== w0)
      $display("FAIL zero_status: got %h writes=%0d want 0000000c 0", rd, wr_cnt - w0);
    else pass_cnt++;
    reg_write(2'd0, 32'h0000_000C);
    @(posedge clk); #1;
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL clr_irq: got irq=%b want 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int a0;
    reg_write(2'd1, 32'h0000_0400);
    reg_write(2'd2, 32'd8);
    reg_write(2'd3, 32'h0000_0055);
    a0 = acc_cnt;
    reg_write(2'd0, 32'h0000_0001);
    reg_write(2'd0, 32'h0000_0001);
    reg_write(2'd1, 32'h0000_0800);
    reg_read(2'd1, rd);
    chk_cnt++;
    if (rd !== 32'h400 || acc_cnt - a0 !== 6)
      $display("FAIL busy_base: got base=%h accepts=%0d want 00000400 6", rd, acc_cnt - a0);
    else pass_cnt++;
    wait_idle();
    chk_cnt++;
    if (m_write !== 1'b0 || acc_cnt - a0 !== 8)
      $display("FAIL busy_go_ignored: got wr=%b accepts=%0d want 0 8", m_write, acc_cnt - a0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    int w0;
    reg_write(2'd1, 32'h0000_0500);
    reg_write(2'd2, 32'd8);
    m_waitrequest = 1'b1;
    reg_write(2'd0, 32'h0000_0007);
    #3;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (m_write !== 1'b0 || m_address !== 32'd0 || irq !== 1'b0)
      $display("FAIL reset_async: got wr=%b addr=%h irq=%b want 0 0 0", m_write, m_address, irq);
    else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    w0 = wr_cnt;
    for (int r = 0; r < 4; r++) begin
      reg_read(r[1:0], rd);
      chk_cnt++;
      if (rd !== 32'd0) $display("FAIL post_reset_reg%0d: got %h want 00000000", r, rd);
      else pass_cnt++;
    end
    chk_cnt++;
    if (wr_cnt !== w0) $display("FAIL post_reset_writes: got %0d want 0", wr_cnt - w0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_const_fill();
    test_inc_wrap();
    test_waitrequest();
    test_abort();
    test_zero_len_irq();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
